sap_cpu_param: RTL

//  Parametrised next-generation SAP core: accumulator CPU with A/B registers, ZF/CF flags,

---
 rtl/sap_cpu_param_if.sv | 14 +
 rtl/sap_cpu_param.sv | 75 +++++++
 2 files changed

// File: rtl/sap_cpu_param_if.sv
// sap_cpu_param_if: control, program-load and ready/valid output bus of the SAP core
interface sap_cpu_param_if #(parameter int DATA_W = 4, parameter int ADDR_W = 4);
  logic run;
  logic prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [3+DATA_W:0] prog_data;
  logic [DATA_W-1:0] port_out;
  logic out_valid;
  logic out_ready;
  logic halted;
  logic busy;
  modport master(output run, prog_we, prog_addr, prog_data, out_ready, input port_out, out_valid, halted, busy);
  modport slave(input run, prog_we, prog_addr, prog_data, out_ready, output port_out, out_valid, halted, busy);
endinterface

// File: rtl/sap_cpu_param.sv
// sap_cpu_param: parametrised SAP accumulator CPU with loadable RAM, flags, jumps and ready/valid output
module sap_cpu_param #(parameter int DATA_W = 4, parameter int ADDR_W = 4) (
  input logic clk,
  input logic rst,
  sap_cpu_param_if.slave bus
);
  localparam int W = 4 + DATA_W;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t state;
  logic [W-1:0] ram [2**ADDR_W];
  logic [W-1:0] ir, mem_rd;
  logic [ADDR_W-1:0] pc, ad;
  logic [DATA_W-1:0] a, b, k, diff;
  logic [DATA_W:0] sum;
  logic [3:0] op;
  logic zf, cf, parked, can_out;
  assign op = ir[W-1:DATA_W];
  assign k = ir[DATA_W-1:0];
  assign ad = k[ADDR_W-1:0];
  assign mem_rd = ram[ad];
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = a - b;
  assign parked = state == IDLE || state == HALT;
  assign can_out = !bus.out_valid || bus.out_ready;
  // loader writes only while parked, so it can never collide with an STA
  always_ff @(posedge clk)
    if (bus.prog_we && parked) ram[bus.prog_addr] <= bus.prog_data;
    else if (!rst && state == EXEC && op == 4'h3) ram[ad] <= W'(a);
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      a <= '0;
      b <= '0;
      zf <= 1'b0;
      cf <= 1'b0;
      bus.port_out <= '0;
      bus.out_valid <= 1'b0;
      bus.halted <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      case (state)
        IDLE, HALT: if (bus.run) begin
          pc <= '0;
          state <= FETCH;
          bus.busy <= 1'b1;
          bus.halted <= 1'b0;
        end
        FETCH: begin
          ir <= ram[pc];
          pc <= pc + 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          case (op)
            4'h1: begin a <= mem_rd[DATA_W-1:0]; zf <= mem_rd[DATA_W-1:0] == '0; end
            4'h2: begin a <= k; zf <= k == '0; end
            4'h4: b <= a;
            4'h5: begin {cf, a} <= sum; zf <= sum[DATA_W-1:0] == '0; end
            4'h6: begin a <= diff; cf <= a < b; zf <= diff == '0; end
            4'h7: pc <= ad;
            4'h8: if (zf) pc <= ad;
            4'h9: if (cf) pc <= ad;
            4'hA: if (can_out) begin bus.port_out <= a; bus.out_valid <= 1'b1; end else state <= EXEC;
            4'hF: begin state <= HALT; bus.busy <= 1'b0; bus.halted <= 1'b1; end
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
endmodule
